// File: rtl/pcileech_com_tx_arb.sv
// Packet-atomic round-robin arbiter for the host-bound COM TX stream.
// A granted requester keeps the stream until its last word or until the watchdog expires.
module pcileech_com_tx_arb #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [32*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [IW-1:0]         grant_id,
    output logic                  busy,
    output logic                  abort,
    output logic [15:0]           abort_cnt
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t        state, state_next;
    logic [IW-1:0] rr;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;
    logic [10:0]   wd;
    logic          g_valid;
    logic          g_last;
    logic [31:0]   g_data;
    logic          accept;
    logic          wd_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Round-robin scan starting just after the last grant, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(rr) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        g_valid    = req_valid[grant_id];
        g_last     = req_last[grant_id];
        g_data     = req_data[32*int'(grant_id) +: 32];
        accept     = (state == XFER) && g_valid && (!out_valid || out_ready);
        req_ready  = NUM_REQ'(accept) << grant_id;
        // Only cycles where the granted source itself is silent count toward the timeout.
        wd_hit     = (state == XFER) && !g_valid && (wd == 11'(TIMEOUT - 2));
        state_next = state;
        case (state)
            IDLE: if (found) state_next = XFER;
            XFER: if ((accept && g_last) || wd_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign busy = (state == XFER);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr        <= IW'(NUM_REQ - 1);
            grant_id  <= '0;
            wd        <= '0;
            abort     <= 1'b0;
            abort_cnt <= '0;
        end else begin
            abort <= wd_hit;
            if (wd_hit) abort_cnt <= sat_inc(abort_cnt);
            if (state == IDLE) begin
                if (found) begin
                    grant_id <= pick;
                    rr       <= pick;
                    wd       <= '0;
                end
            end else if (accept || wd_hit) begin
                wd <= '0;
            end else if (!g_valid) begin
                wd <= wd + 11'd1;
            end
        end
    end

    // Output register: loads on accept, empties when downstream takes the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_last  <= g_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pcileech_com_tx_arb.sv
// Scoreboard bench for pcileech_com_tx_arb: per-requester source queues feed the DUT,
// predicted output words are queued up front and popped on every output handshake.
module tb_pcileech_com_tx_arb;

    localparam int NR = 4;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } word_t;

    logic            clk;
    logic            rst;
    logic [32*NR-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [31:0]     out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            abort;
    logic [15:0]     abort_cnt;

    logic [NR-1:0]   fire_q;
    word_t           src_q[NR][$];
    word_t           exp_q[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              abort_seen = 0;

    pcileech_com_tx_arb #(.NUM_REQ(NR), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort     (abort),
        .abort_cnt (abort_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input int r, input logic [31:0] d, input logic l);
        src_q[r].push_back({d, l});
    endtask

    task automatic expect_w(input logic [31:0] d, input logic l);
        exp_q.push_back({d, l});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        exp_q.delete();
        step(2);
        rst = 1'b0;
    endtask

    always @(posedge clk) fire_q <= req_valid & req_ready;

    // Source model: hold the head word until the DUT accepts it.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (fire_q[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[32*i +: 32] = src_q[i][0].d;
                    req_last[i]          = src_q[i][0].l;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (abort) abort_seen++;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", out_data, 32'hDEAD_BEEF);
            end else begin
                check("sb_data", out_data, exp_q[0].d);
                check("sb_last", {31'd0, out_last}, {31'd0, exp_q[0].l});
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [10:0] pat;
        int          guard;
        rst       = 1'b1;
        out_ready = 1'b1;
        step(3);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_req_ready", {28'd0, req_ready}, 0);
        check("rst_grant", {30'd0, grant_id}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_abort_cnt", {16'd0, abort_cnt}, 0);
        rst = 1'b0;

        // T1: single 3-word packet from req0
        push(0, 32'hA000_0000, 1'b0); push(0, 32'hA000_0001, 1'b0); push(0, 32'hA000_0002, 1'b1);
        expect_w(32'hA000_0000, 1'b0); expect_w(32'hA000_0001, 1'b0); expect_w(32'hA000_0002, 1'b1);
        step(1);
        check("t1_valid_e1", {31'd0, out_valid}, 0);
        step(1);
        check("t1_busy_e2", {31'd0, busy}, 1);
        check("t1_valid_e2", {31'd0, out_valid}, 0);
        step(1);
        check("t1_d0", out_data, 32'hA000_0000);
        check("t1_last0", {31'd0, out_last}, 0);
        step(1);
        check("t1_d1", out_data, 32'hA000_0001);
        step(1);
        check("t1_d2", out_data, 32'hA000_0002);
        check("t1_last2", {31'd0, out_last}, 1);
        step(1);
        check("t1_valid_end", {31'd0, out_valid}, 0);
        check("t1_busy_end", {31'd0, busy}, 0);

        // T2: req0 and req2 contend with back-to-back 2-word packets
        do_reset();
        push(0, 32'hB0, 1'b0); push(0, 32'hB1, 1'b1); push(0, 32'hB2, 1'b0); push(0, 32'hB3, 1'b1);
        push(2, 32'hC0, 1'b0); push(2, 32'hC1, 1'b1); push(2, 32'hC2, 1'b0); push(2, 32'hC3, 1'b1);
        expect_w(32'hB0, 1'b0); expect_w(32'hB1, 1'b1); expect_w(32'hC0, 1'b0); expect_w(32'hC1, 1'b1);
        expect_w(32'hB2, 1'b0); expect_w(32'hB3, 1'b1); expect_w(32'hC2, 1'b0); expect_w(32'hC3, 1'b1);
        pat = 11'b110_1101_1011;
        step(2);
        for (int k = 0; k < 11; k++) begin
            step(1);
            check($sformatf("t2_gap_%0d", k), {31'd0, out_valid}, {31'd0, pat[k]});
        end
        step(2);

        // T3: downstream stall mid-packet from req1
        push(1, 32'hD0, 1'b0); push(1, 32'hD1, 1'b0); push(1, 32'hD2, 1'b0); push(1, 32'hD3, 1'b1);
        expect_w(32'hD0, 1'b0); expect_w(32'hD1, 1'b0); expect_w(32'hD2, 1'b0); expect_w(32'hD3, 1'b1);
        step(3);
        check("t3_first", out_data, 32'hD0);
        check("t3_grant", {30'd0, grant_id}, 1);
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("t3_hold_data", out_data, 32'hD0);
            check("t3_hold_ready", {28'd0, req_ready}, 0);
            check("t3_no_abort", {31'd0, abort}, 0);
        end
        out_ready = 1'b1;
        step(6);
        check("t3_done", {31'd0, busy}, 0);

        // T4: req1 stalls after one word, watchdog reclaims, req3 follows
        push(1, 32'hE0, 1'b0);
        expect_w(32'hE0, 1'b0); expect_w(32'hF0, 1'b1);
        step(2);
        check("t4_grant1", {30'd0, grant_id}, 1);
        push(3, 32'hF0, 1'b1);
        step(1);
        step(14);
        check("t4_abort_early", {31'd0, abort}, 0);
        step(1);
        check("t4_abort", {31'd0, abort}, 1);
        check("t4_abort_cnt", {16'd0, abort_cnt}, 1);
        step(1);
        check("t4_abort_pulse", {31'd0, abort}, 0);
        check("t4_grant3", {30'd0, grant_id}, 3);
        check("t4_busy", {31'd0, busy}, 1);
        step(4);

        // T5: pointer wrap from 3 to 0
        push(0, 32'h60, 1'b1); push(3, 32'h63, 1'b1);
        expect_w(32'h60, 1'b1); expect_w(32'h63, 1'b1);
        step(2);
        check("t5_grant0", {30'd0, grant_id}, 0);
        step(4);
        check("t5_grant3", {30'd0, grant_id}, 3);
        step(2);

        // T6: reset in the middle of a req2 packet
        push(2, 32'h70, 1'b0); push(2, 32'h71, 1'b0); push(2, 32'h72, 1'b1);
        expect_w(32'h70, 1'b0);
        step(4);
        rst = 1'b1;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        step(1);
        check("t6_out_valid", {31'd0, out_valid}, 0);
        check("t6_out_data", out_data, 0);
        check("t6_out_last", {31'd0, out_last}, 0);
        check("t6_req_ready", {28'd0, req_ready}, 0);
        check("t6_grant", {30'd0, grant_id}, 0);
        check("t6_busy", {31'd0, busy}, 0);
        check("t6_abort_cnt", {16'd0, abort_cnt}, 0);
        rst = 1'b0;
        push(1, 32'h81, 1'b1); push(0, 32'h80, 1'b1);
        expect_w(32'h80, 1'b1); expect_w(32'h81, 1'b1);
        step(2);
        check("t6_first_req0", {30'd0, grant_id}, 0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            step(1);
            guard++;
        end
        check("drain", exp_q.size(), 0);
        check("abort_total", abort_seen, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
